melay_pair_tx: RTL and testbench

//  Transmit side of the single-line pulse-pair protocol decoded by our Mealy

---
 rtl/melay_pair_tx_if.sv | 15 +
 rtl/melay_pair_tx.sv | 112 +++++++++++
 tb/tb_melay_pair_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/melay_pair_tx_if.sv
// Request/status bundle between a pulse-pair transmitter and its client.
// The transmitter takes the slave side; the client drives req from the master side.
interface melay_pair_tx_if #(
   parameter int CNT_W = 4
);
   logic             req;
   logic             dout;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pend_cnt;
   logic             ovf;

   modport master (output req, input dout, busy, done, pend_cnt, ovf);
   modport slave  (input req, output dout, busy, done, pend_cnt, ovf);
endinterface

// File: rtl/melay_pair_tx.sv
// Pulse-pair transmitter: every queued request goes out as two 1-cycle highs on
// dout with programmable low gap and tail, so the far-end decimator yields one pulse.
module melay_pair_tx #(
   parameter int GAP_W  = 1,
   parameter int TAIL_W = 1,
   parameter int CNT_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   melay_pair_tx_if.slave  tx_if
);
   localparam int TMR_MAX = (GAP_W > TAIL_W) ? GAP_W : TAIL_W;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

   typedef enum logic [2:0] {IDLE, HI1, GAP, HI2, TAIL} state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tail_end;
   logic             start;

   // A pair starts from IDLE or straight out of a finished tail when work is queued.
   assign tail_end = (state_q == TAIL) && (tmr_q == TMR_W'(1));
   assign start    = ((state_q == IDLE) || tail_end) && (pend_q != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      unique case (state_q)
         IDLE: if (start) state_d = HI1;
         HI1: begin
            state_d = GAP;
            tmr_d   = TMR_W'(GAP_W);
         end
         GAP: begin
            if (tmr_q == TMR_W'(1)) begin
               state_d = HI2;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         HI2: begin
            state_d = TAIL;
            tmr_d   = TMR_W'(TAIL_W);
         end
         TAIL: begin
            if (tail_end) begin
               state_d = start ? HI1 : IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A request arriving at saturation survives only if a pair start frees a slot.
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (tx_if.req && !start) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + CNT_W'(1);
      end else if (!tx_if.req && start) begin
         pend_d = pend_q - CNT_W'(1);
      end
   end

   // Outputs decode the next state so the registered line matches the state timing.
   always_comb begin
      dout_d = (state_d == HI1) || (state_d == HI2);
      busy_d = (state_d != IDLE);
      done_d = tail_end && !start;
   end

   assign tx_if.dout     = dout_q;
   assign tx_if.busy     = busy_q;
   assign tx_if.done     = done_q;
   assign tx_if.pend_cnt = pend_q;
   assign tx_if.ovf      = ovf_q;
endmodule

// File: tb/tb_melay_pair_tx.sv
// Directed bench for melay_pair_tx: three instances cover default timing,
// stretched gap/tail, and a narrow pending counter that saturates.
module tb_melay_pair_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   melay_pair_tx_if #(.CNT_W(4)) a_if ();
   melay_pair_tx_if #(.CNT_W(4)) b_if ();
   melay_pair_tx_if #(.CNT_W(2)) c_if ();

   melay_pair_tx #(.GAP_W(1), .TAIL_W(1), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .tx_if(a_if.slave));
   melay_pair_tx #(.GAP_W(3), .TAIL_W(2), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .tx_if(b_if.slave));
   melay_pair_tx #(.GAP_W(1), .TAIL_W(1), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .tx_if(c_if.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      a_if.req = 1'b0;
      b_if.req = 1'b0;
      c_if.req = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] exp_v;
      logic       tog;
      int         pulses;
      int         dones;

      // Single request, default timing; c0 doubles as the reset-state check
      do_reset();
      check("reset ovf", 32'(a_if.ovf), 32'd0);
      for (int c = 0; c <= 8; c++) begin
         a_if.req = (c == 0);
         @(negedge clk);
         exp_v = {(c == 2 || c == 4), (c >= 2 && c <= 5), (c == 6), (c == 1) ? 4'd1 : 4'd0};
         check($sformatf("t1 c%0d", c),
               32'({a_if.dout, a_if.busy, a_if.done, a_if.pend_cnt}), 32'(exp_v));
         end_cycle();
      end

      // Three requests held c0..c2, back-to-back pairs, decoder counts pulses
      do_reset();
      tog = 1'b0;
      pulses = 0;
      for (int c = 0; c <= 16; c++) begin
         a_if.req = (c <= 2);
         @(negedge clk);
         if (a_if.dout) begin
            if (tog) pulses++;
            tog = ~tog;
         end
         check($sformatf("t2 c%0d dout/done", c), 32'({a_if.dout, a_if.done}),
               32'({(c >= 2 && c <= 12 && (c % 2 == 0)), (c == 14)}));
         if (c == 2) check("t2 pend req+start", 32'(a_if.pend_cnt), 32'd1);
         if (c == 3) check("t2 pend c3", 32'(a_if.pend_cnt), 32'd2);
         if (c == 6) check("t2 pend c6", 32'(a_if.pend_cnt), 32'd1);
         end_cycle();
      end
      check("t2 decoder pulses", 32'(pulses), 32'd3);

      // GAP_W=3, TAIL_W=2
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         b_if.req = (c == 0);
         @(negedge clk);
         check($sformatf("t3 c%0d", c), 32'({b_if.dout, b_if.busy, b_if.done}),
               32'({(c == 2 || c == 6), (c >= 2 && c <= 8), (c == 9)}));
         end_cycle();
      end

      // CNT_W=2 saturation: req held c0..c5, one dropped at c4
      do_reset();
      tog = 1'b0;
      pulses = 0;
      dones = 0;
      for (int c = 0; c <= 29; c++) begin
         c_if.req = (c <= 5);
         @(negedge clk);
         if (c_if.dout) begin
            if (tog) pulses++;
            tog = ~tog;
         end
         if (c_if.done) dones++;
         if (c == 4) check("t4 pend sat", 32'(c_if.pend_cnt), 32'd3);
         if (c == 4) check("t4 ovf before drop", 32'(c_if.ovf), 32'd0);
         if (c == 5) check("t4 ovf set", 32'(c_if.ovf), 32'd1);
         if (c == 6) check("t4 pend req+start at max", 32'(c_if.pend_cnt), 32'd3);
         end_cycle();
      end
      check("t4 pairs sent", 32'(pulses), 32'd5);
      check("t4 done count", 32'(dones), 32'd1);
      check("t4 ovf sticky", 32'(c_if.ovf), 32'd1);

      // Reset mid-pair (during GAP), then a fresh request
      for (int c = 0; c <= 7; c++) begin
         a_if.req = (c <= 1) || (c == 4);
         rst = (c == 3);
         @(negedge clk);
         if (c == 3) check("t5 in gap", 32'({a_if.dout, a_if.busy, a_if.pend_cnt}), 32'({1'b0, 1'b1, 4'd1}));
         if (c == 4) begin
            check("t5 after rst", 32'({a_if.dout, a_if.busy, a_if.pend_cnt, a_if.ovf}), 32'd0);
            check("t5 ovf cleared", 32'(c_if.ovf), 32'd0);
         end
         if (c == 5) check("t5 pend new req", 32'({a_if.dout, a_if.pend_cnt}), 32'({1'b0, 4'd1}));
         if (c == 6) check("t5 latency 2", 32'({a_if.dout, a_if.busy}), 32'b11);
         end_cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
